// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2 FFT butterfly sequencer.
// bfly_addr is a width-generic reference for butterfly addressing.
package fft_ctrl_pkg;

  localparam int STAGE_W   = 4;
  localparam int MAX_LOG2N = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_RELEASE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr_a;
    logic [MAX_LOG2N-1:0] addr_b;
    logic [MAX_LOG2N-2:0] tw_idx;
  } bfly_t;

  // Addresses are computed at the widest legal size; callers keep the low bits.
  function automatic bfly_t bfly_addr(input int unsigned          log2n,
                                      input logic [STAGE_W-1:0]   stage,
                                      input logic [MAX_LOG2N-2:0] b);
    bfly_t                r;
    logic [MAX_LOG2N-1:0] b_w;
    logic [MAX_LOG2N-1:0] half;
    logic [MAX_LOG2N-1:0] j;
    logic [MAX_LOG2N-1:0] tw_w;
    b_w      = {1'b0, b};
    half     = MAX_LOG2N'(1) << stage;
    j        = b_w & (half - MAX_LOG2N'(1));
    r.addr_a = ((b_w >> stage) << (stage + STAGE_W'(1))) | j;
    r.addr_b = r.addr_a + half;
    tw_w     = j << (log2n - 1 - 32'(stage));
    r.tw_idx = tw_w[MAX_LOG2N-2:0];
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Registered operand-address and twiddle-index generator for one butterfly.
// Loads on entry to ISSUE and holds until the next load or clear.
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [LOG2N-2:0]   b_i,
  output logic [LOG2N-1:0]   addr_a_o,
  output logic [LOG2N-1:0]   addr_b_o,
  output logic [LOG2N-2:0]   tw_idx_o
);

  logic [LOG2N-1:0] b_w;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] addr_a_d;
  logic [LOG2N-1:0] addr_b_d;
  logic [LOG2N-2:0] tw_idx_d;

  // j < half <= N/2, so its top bit is always clear and tw_idx never overflows.
  always_comb begin
    b_w      = {1'b0, b_i};
    half     = LOG2N'(1) << stage_i;
    j        = b_w & (half - LOG2N'(1));
    addr_a_d = ((b_w >> stage_i) << (stage_i + STAGE_W'(1))) | j;
    addr_b_d = addr_a_d + half;
    tw_idx_d = j[LOG2N-2:0] << (STAGE_W'(LOG2N - 1) - stage_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_o <= '0;
      addr_b_o <= '0;
      tw_idx_o <= '0;
    end else if (clear_i) begin
      addr_a_o <= '0;
      addr_b_o <= '0;
      tw_idx_o <= '0;
    end else if (load_i) begin
      addr_a_o <= addr_a_d;
      addr_b_o <= addr_b_d;
      tw_idx_o <= tw_idx_d;
    end
  end

endmodule

// File: rtl/fft_butterfly_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT; drives the
// twiddle multiplier handshake and one write-back strobe per butterfly.
module fft_butterfly_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mul_en,
  input  logic               mul_ready,
  output logic               mul_cycle_finish,
  output logic [LOG2N-1:0]   addr_a,
  output logic [LOG2N-1:0]   addr_b,
  output logic [LOG2N-2:0]   tw_idx,
  output logic [STAGE_W-1:0] stage,
  output logic               wr_en
);

  localparam int                 BW         = LOG2N - 1;
  localparam int                 TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [BW-1:0]      B_LAST     = {BW{1'b1}};

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BW-1:0]      b_q, b_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          err_d   = 1'b0;
          stage_d = '0;
          b_d     = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (mul_ready) begin
          state_d = ST_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WRITE: begin
        state_d = ST_RELEASE;
        tmo_d   = '0;
      end
      ST_RELEASE: begin
        // mul_ready low means the multiplier has returned to idle.
        if (!mul_ready) begin
          if (b_q != B_LAST) begin
            b_d     = b_q + BW'(1);
            state_d = ST_ISSUE;
          end else if (stage_q != STAGE_LAST) begin
            b_d     = '0;
            stage_d = stage_q + STAGE_W'(1);
            state_d = ST_ISSUE;
          end else begin
            b_d     = '0;
            stage_d = '0;
            state_d = ST_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        b_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      b_q     <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Fed with next-state counters so the registered addresses line up with ISSUE.
  fft_addr_gen #(
    .LOG2N(LOG2N)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_d == ST_IDLE),
    .load_i   (state_d == ST_ISSUE),
    .stage_i  (stage_d),
    .b_i      (b_d),
    .addr_a_o (addr_a),
    .addr_b_o (addr_b),
    .tw_idx_o (tw_idx)
  );

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign mul_en           = (state_q == ST_ISSUE);
  assign mul_cycle_finish = (state_q == ST_WRITE);
  assign wr_en            = (state_q == ST_WRITE);
  assign err              = err_q;
  assign stage            = stage_q;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Directed bench for fft_butterfly_sequencer (N=8) with a model multiplier
// of configurable ready latency.
module tb_fft_butterfly_sequencer;
  import fft_ctrl_pkg::*;

  localparam int LOG2N   = 3;
  localparam int TIMEOUT = 15;
  localparam int NB      = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy, done, err, mul_en, mul_ready, mul_cycle_finish, wr_en;
  logic [2:0]   addr_a, addr_b;
  logic [1:0]   tw_idx;
  logic [3:0]   stage;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  int   lat   = 3;
  logic stuck = 1'b0;
  int   mcnt;

  int   en_cnt, wr_cnt, done_cnt, viol;
  logic prev_en, prev_cf;
  int   iss_a[32], iss_b[32], iss_t[32];
  int   wr_a[32], wr_b[32], wr_t[32], wr_s[32];

  int exp_a[NB] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[NB] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_t[NB] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;

  fft_butterfly_sequencer #(
    .LOG2N   (LOG2N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .mul_en           (mul_en),
    .mul_ready        (mul_ready),
    .mul_cycle_finish (mul_cycle_finish),
    .addr_a           (addr_a),
    .addr_b           (addr_b),
    .tw_idx           (tw_idx),
    .stage            (stage),
    .wr_en            (wr_en)
  );

  // Model multiplier: ready rises `lat` edges after EN is sampled, drops after cycle_finish.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          mcnt <= 0;
    else if (stuck || mul_cycle_finish)  mcnt <= 0;
    else if (mul_en)                     mcnt <= 1;
    else if (mcnt != 0 && mcnt < lat)    mcnt <= mcnt + 1;
  end
  assign mul_ready = (mcnt != 0) && (mcnt >= lat);

  // Mid-cycle monitor: records issued/written butterflies and handshake pulse rules.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_en) begin
        if (en_cnt < 32) begin
          iss_a[en_cnt] = int'(addr_a);
          iss_b[en_cnt] = int'(addr_b);
          iss_t[en_cnt] = int'(tw_idx);
        end
        en_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt < 32) begin
          wr_a[wr_cnt] = int'(addr_a);
          wr_b[wr_cnt] = int'(addr_b);
          wr_t[wr_cnt] = int'(tw_idx);
          wr_s[wr_cnt] = int'(stage);
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
      if ((mul_en && mul_cycle_finish) || (mul_en && prev_en) ||
          (mul_cycle_finish && prev_cf) || (wr_en !== mul_cycle_finish))
        viol++;
      prev_en = mul_en;
      prev_cf = mul_cycle_finish;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, busy, done, err, mul_en, mul_cycle_finish, wr_en,
            stage, addr_a, addr_b, tw_idx};
  endfunction

  task automatic clear_mon();
    en_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    viol     = 0;
    prev_en  = 1'b0;
    prev_cf  = 1'b0;
  endtask

  // Pulses start and leaves the bench #1 into cycle 1 (the ISSUE of butterfly 0).
  task automatic launch();
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("busy_rise", busy, 1);
    check("err_cleared", err, 0);
    check("first_issue_en", mul_en, 1);
    check("first_stage", stage, 0);
    check("first_addr", {addr_a, addr_b, tw_idx}, {3'd0, 3'd1, 2'd0});
  endtask

  task automatic run_to_done(input bit poke);
    while (done !== 1'b1 && n < 400) begin
      start = poke && (n >= 20) && (n < 24);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic finish_run(input int exp_done, input bit poke);
    check("done_cycle", n, exp_done);
    check("done_busy", busy, 1);
    check("done_err", err, 0);
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_outs", outs(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("stay_idle", busy, 0);
    check("wr_pulses", wr_cnt, NB);
    check("en_pulses", en_cnt, NB);
    check("done_pulses", done_cnt, 1);
    check("handshake_rules", viol, 0);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("wr_addr[%0d]", k), {wr_a[k][7:0], wr_b[k][7:0], wr_t[k][7:0]},
            {exp_a[k][7:0], exp_b[k][7:0], exp_t[k][7:0]});
      check($sformatf("issue_addr[%0d]", k), {iss_a[k][7:0], iss_b[k][7:0], iss_t[k][7:0]},
            {exp_a[k][7:0], exp_b[k][7:0], exp_t[k][7:0]});
      check($sformatf("wr_stage[%0d]", k), wr_s[k], k / 4);
    end
  endtask

  initial begin
    bfly_t r;
    rst_n = 1'b1;
    start = 1'b1;
    clear_mon();
    #1 rst_n = 1'b0;

    // Reset held with start high: nothing moves.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    #1;
    check("release_outs", outs(), 0);

    // Full run, start poked while busy and again in DONE.
    lat = 3;
    launch();
    run_to_done(1'b1);
    finish_run(73, 1'b1);

    // Multiplier never answers: timeout after 15 WAIT cycles.
    stuck = 1'b1;
    launch();
    run_to_done(1'b0);
    check("tmo_done_cycle", n, 17);
    check("tmo_err", err, 1);
    check("tmo_done", done, 1);
    check("tmo_no_write", wr_cnt, 0);
    @(posedge clk); #1;
    check("tmo_idle", busy, 0);
    check("tmo_err_sticky", err, 1);
    repeat (4) @(posedge clk);
    #1;
    check("tmo_err_still", err, 1);
    stuck = 1'b0;

    // Slower multiplier: same sequence, 8 cycles per butterfly; launch checks err cleared.
    lat = 5;
    launch();
    run_to_done(1'b0);
    finish_run(97, 1'b0);

    // Reset during the first stage-1 butterfly's WAIT.
    lat = 3;
    launch();
    while (n < 27) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_stage", stage, 1);
    check("mid_waiting", {busy, mul_en, wr_en}, 3'b100);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_release_outs", outs(), 0);

    launch();
    run_to_done(1'b0);
    finish_run(73, 1'b0);

    // Package reference function spot checks.
    r = bfly_addr(3, 4'd1, 9'd1);
    check("pkg_s1_b1", {r.addr_a, r.addr_b, r.tw_idx}, {10'd1, 10'd3, 9'd2});
    r = bfly_addr(3, 4'd2, 9'd3);
    check("pkg_s2_b3", {r.addr_a, r.addr_b, r.tw_idx}, {10'd3, 10'd7, 9'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
